switch_box_config_loader: RTL and testbench
===========================================

SWITCH_BOX_CONFIG_LOADER -- requirements
Module: switch_box_config_loader

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 384, meaning width of the switch box configuration vector.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, meaning width of one bitstream word; CONFIG_WIDTH SHALL be an integer multiple of WORD_WIDTH.
REQ-003 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port word_in  input  WORD_WIDTH  bitstream word.
REQ-006 SHALL have port word_valid  input  1  word_in holds a valid word.
REQ-007 SHALL have port word_ready  output  1  loader accepts a word this cycle.
REQ-008 SHALL have port commit  input  1  one-cycle request to apply the shadow configuration.
REQ-009 SHALL have port clear  input  1  discard partial load and return to IDLE.
REQ-010 SHALL have port full  output  1  shadow holds CONFIG_WIDTH/WORD_WIDTH new words.
REQ-011 SHALL have port error  output  1  sticky: commit requested while not full.
REQ-012 SHALL have port config_out  output  CONFIG_WIDTH  active configuration; drives the switch box config_in.

Function
REQ-013 SHALL define NWORDS = CONFIG_WIDTH/WORD_WIDTH (12 at defaults) and a word counter of ceil(log2(NWORDS)) bits.
REQ-014 SHALL implement states IDLE, LOAD, FULL.
REQ-015 A word SHALL be accepted exactly when word_valid and word_ready are both 1 on a rising edge.
REQ-016 word_ready SHALL be 1 in IDLE and LOAD and 0 in FULL.
REQ-017 Accepted word k (0-based) SHALL be written to shadow bits [k*WORD_WIDTH +: WORD_WIDTH]; word 0 is least significant.
REQ-018 IDLE: an accepted word SHALL store at index 0; next state is LOAD (FULL if NWORDS=1), counter = 1.
REQ-019 LOAD: each accepted word SHALL store at the counter index and increment the counter; the word at index NWORDS-1 SHALL move to FULL and clear the counter.
REQ-020 full SHALL be 1 exactly while in FULL.
REQ-021 FULL with commit=1: config_out SHALL take the shadow value on that edge (visible the next cycle); next state IDLE.
REQ-022 commit in IDLE or LOAD SHALL set error, SHALL NOT change config_out, state, or counter.
REQ-023 clear=1 SHALL force IDLE and counter 0 on that edge; it overrides a simultaneous commit or accepted word; config_out and error are unchanged.
REQ-024 error SHALL remain set until reset.
REQ-025 config_out SHALL change only on a valid commit; a partial load SHALL never reach config_out.
REQ-026 Shadow contents SHALL persist after commit; unwritten words of a new load SHALL be overwritten before the next FULL.

Reset
REQ-027 On reset: state IDLE, counter 0, shadow 0, config_out 0, error 0, full 0, word_ready 1 the following cycle.
REQ-028 Reset mid-load or in FULL SHALL discard the shadow; reset SHALL dominate clear, commit, and word_valid.

Structure
REQ-029 The state encoding type and defaults for CONFIG_WIDTH/WORD_WIDTH SHALL live in the shared kfpga package; NWORDS is derived locally.
REQ-030 No sub-module is required; the FSM, counter, shadow register, and active register SHALL be in one module.

Verification
REQ-031 Reset, then 12 words 0x00000001..0x0000000C, each with valid held 1, then commit -> full=1 after the 12th accept, config_out[31:0]=1 and [383:352]=0xC one cycle after commit, state IDLE.
REQ-032 5 words, then commit -> error=1, config_out unchanged (0), next 7 words still reach full.
REQ-033 In FULL, hold word_valid=1 with 0xDEADBEEF for 3 cycles -> word_ready=0 and no shadow change; commit then applies the original 12 words.
REQ-034 6 words, clear, then 12 words 0xA5A5A5A5, commit -> config_out = 12 copies of 0xA5A5A5A5.
REQ-035 Commit and clear asserted together in FULL -> state IDLE, config_out unchanged, error unchanged.
REQ-036 Reset asserted after word 8 -> config_out=0, error=0, and a fresh 12-word load plus commit works normally.

Source files
------------

// File: rtl/kfpga_pkg.sv
// Shared kfpga definitions: loader state encoding and default configuration geometry.
package kfpga_pkg;

    localparam int KF_CONFIG_WIDTH = 384;
    localparam int KF_WORD_WIDTH   = 32;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_FULL = 2'd2
    } loader_state_t;

endpackage

// File: rtl/switch_box_config_loader.sv
// Purpose: shifts a word stream into a shadow register and applies it to config_out on commit.
// Latency: config_out updates on the commit edge and is visible one cycle later.
// Backpressure: word_ready drops while the shadow is full, until a commit or clear releases it.
module switch_box_config_loader
    import kfpga_pkg::*;
#(
    parameter int CONFIG_WIDTH = KF_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = KF_WORD_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    input  logic                    commit,
    input  logic                    clear,
    output logic                    full,
    output logic                    error,
    output logic [CONFIG_WIDTH-1:0] config_out
);

    // CONFIG_WIDTH must be a whole number of words.
    localparam int NWORDS = CONFIG_WIDTH / WORD_WIDTH;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    loader_state_t           state_q, state_nxt;
    logic [CW-1:0]           count_q, count_nxt;
    logic [CW-1:0]           wr_idx;
    logic                    wr_en;
    logic                    apply;
    logic                    err_set;
    logic                    accept;
    logic [CONFIG_WIDTH-1:0] shadow_q;
    logic [CONFIG_WIDTH-1:0] config_q;
    logic                    error_q;

    assign word_ready = (state_q != LDR_FULL);
    assign full       = (state_q == LDR_FULL);
    assign error      = error_q;
    assign config_out = config_q;
    assign accept     = word_valid && word_ready;

    always_comb begin
        state_nxt = state_q;
        count_nxt = count_q;
        wr_idx    = count_q;
        wr_en     = 1'b0;
        apply     = 1'b0;
        err_set   = 1'b0;
        // clear wins over everything except reset, including a handshake on the same edge
        if (clear) begin
            state_nxt = LDR_IDLE;
            count_nxt = '0;
        end else begin
            unique case (state_q)
                LDR_IDLE: begin
                    err_set = commit;
                    if (accept) begin
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        if (NWORDS == 1) begin
                            state_nxt = LDR_FULL;
                            count_nxt = '0;
                        end else begin
                            state_nxt = LDR_LOAD;
                            count_nxt = CW'(1);
                        end
                    end
                end
                LDR_LOAD: begin
                    err_set = commit;
                    if (accept) begin
                        wr_en = 1'b1;
                        if (count_q == LAST_IDX) begin
                            state_nxt = LDR_FULL;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count_q + CW'(1);
                        end
                    end
                end
                LDR_FULL: begin
                    if (commit) begin
                        apply     = 1'b1;
                        state_nxt = LDR_IDLE;
                    end
                end
                default: begin
                    state_nxt = LDR_IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= LDR_IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            config_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
            if (wr_en) begin
                shadow_q[int'(wr_idx)*WORD_WIDTH +: WORD_WIDTH] <= word_in;
            end
            // shadow is left intact after apply so it can be inspected or re-applied
            if (apply) begin
                config_q <= shadow_q;
            end
            if (err_set) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Randomized and directed stimulus against a word-array reference model of the loader.
module tb_switch_box_config_loader;
    import kfpga_pkg::*;

    localparam int CW = KF_CONFIG_WIDTH;
    localparam int WW = KF_WORD_WIDTH;
    localparam int NW = CW / WW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [WW-1:0] word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic          commit = 1'b0;
    logic          clear = 1'b0;
    logic          full;
    logic          error;
    logic [CW-1:0] config_out;

    switch_box_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
        .clock      (clock),
        .reset      (reset),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .commit     (commit),
        .clear      (clear),
        .full       (full),
        .error      (error),
        .config_out (config_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model: words collected so far, and the two word arrays
    logic [WW-1:0] m_shadow [NW];
    logic [WW-1:0] m_cfg    [NW];
    int            m_n    = 0;
    bit            m_full = 1'b0;
    bit            m_err  = 1'b0;

    task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] model_cfg();
        logic [CW-1:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) v[i*WW +: WW] = m_cfg[i];
        return v;
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_full = 1'b0;
        m_err  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            m_shadow[i] = '0;
            m_cfg[i]    = '0;
        end
    endtask

    task automatic cycle(input bit rst, input bit vld, input logic [WW-1:0] w,
                         input bit cm, input bit clr);
        bit was_full;
        reset      = rst;
        word_valid = vld;
        word_in    = w;
        commit     = cm;
        clear      = clr;
        @(posedge clock);
        #1;
        was_full = m_full;
        if (rst) begin
            model_reset();
        end else if (clr) begin
            m_n    = 0;
            m_full = 1'b0;
        end else begin
            if (was_full && cm) begin
                for (int i = 0; i < NW; i++) m_cfg[i] = m_shadow[i];
                m_full = 1'b0;
                m_n    = 0;
            end else if (cm) begin
                m_err = 1'b1;
            end
            if (!was_full && vld) begin
                m_shadow[m_n] = w;
                m_n++;
                if (m_n == NW) begin
                    m_full = 1'b1;
                    m_n    = 0;
                end
            end
        end
        check_val("word_ready", CW'(word_ready), CW'(!m_full));
        check_val("full",       CW'(full),       CW'(m_full));
        check_val("error",      CW'(error),      CW'(m_err));
        check_val("config_out", config_out,      model_cfg());
    endtask

    task automatic load_words(input int n, input logic [WW-1:0] base, input bit incr);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b1, incr ? base + WW'(i) : base, 1'b0, 1'b0);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [CW-1:0] rep;
        model_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h1234, 1'b1, 1'b1);
        check_val("reset_cfg", config_out, '0);

        // full load of 1..12 then commit
        load_words(NW, 32'd1, 1'b1);
        check_val("full_after_12", CW'(full), CW'(1));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_val("cfg_w0",  CW'(config_out[31:0]),    CW'(32'd1));
        check_val("cfg_w11", CW'(config_out[383:352]), CW'(32'd12));
        check_val("idle_rdy", CW'(word_ready), CW'(1));

        // early commit flags error and leaves config_out alone
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        load_words(5, 32'h100, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_val("early_err", CW'(error), CW'(1));
        check_val("early_cfg", config_out, '0);
        load_words(NW - 5, 32'h105, 1'b1);
        check_val("early_full", CW'(full), CW'(1));

        // words offered while full are refused
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_val("hold_w0",  CW'(config_out[31:0]),    CW'(32'h100));
        check_val("hold_w11", CW'(config_out[383:352]), CW'(32'h10B));

        // clear discards a partial load
        load_words(6, 32'h77, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        load_words(NW, 32'hA5A5A5A5, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        rep = {NW{32'hA5A5A5A5}};
        check_val("a5_cfg", config_out, rep);

        // commit together with clear in FULL: clear wins
        load_words(NW, 32'h5000, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check_val("cc_cfg",  config_out, rep);
        check_val("cc_full", CW'(full), CW'(0));

        // reset mid-load, then a normal load
        load_words(8, 32'h9000, 1'b1);
        cycle(1'b1, 1'b1, 32'hFFFF, 1'b0, 1'b0);
        check_val("rst_cfg", config_out, '0);
        check_val("rst_err", CW'(error), CW'(0));
        load_words(NW, 32'hC00, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_val("rst_reload_w0", CW'(config_out[31:0]), CW'(32'hC00));
        idle_cycle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 7,
                  WW'($urandom),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
